comparator: RTL and testbench
=============================

Name: comparator

Overview:
Registered magnitude comparator. Compares two WIDTH-bit operands A and B and reports exactly one of less / equal / greater. Outputs appear one clock after the operands are sampled. Used as a leaf building block wherever an ordered relation between two small unsigned (optionally signed) values is needed.

Parameters:
WIDTH, 2, operand width in bits (legal range 1..32).
SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  A and B are sampled and compared on this cycle.
A  input  WIDTH  first operand.
B  input  WIDTH  second operand.
out_valid  output  1  result flags correspond to a sampled operand pair.
A_less_B  output  1  registered: A < B.
A_equal_B  output  1  registered: A == B.
A_greater_B  output  1  registered: A > B.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). No asynchronous paths.
- Reset: on any rising clk edge with rst=1:
  - out_valid=0, A_less_B=0, A_equal_B=0, A_greater_B=0.
  - rst overrides in_valid on the same edge. The pair presented on that cycle is discarded.
  - Reset mid-stream drops any pending result.
- Latency: 1 cycle.
  - If in_valid=1 at edge N, the flags for that A/B pair are visible after edge N.
  - out_valid=1 for exactly that cycle, unless in_valid is also 1 at edge N+1.
- Throughput: one compare per cycle. Back-to-back in_valid produces back-to-back out_valid. No backpressure.
- When in_valid=0 at an edge (rst=0):
  - out_valid goes 0.
  - The three flags hold their last values.
- Invariants:
  - Whenever out_valid=1, exactly one of the three flags is 1 (one-hot).
  - After reset and before the first valid sample, all three flags are 0.
- Arithmetic:
  - SIGNED=0: operands are unsigned, range 0..2^WIDTH-1.
  - SIGNED=1: the MSB is the sign bit.
  - No wrap or overflow is possible; the compare is exact over the full operand range.
  - Upstream truncation is the caller's concern. Example, WIDTH=2: an input value of 4 arrives as 0.
- Boundaries:
  - A=B=0 and A=B=max give equal.
  - A=max, B=0 gives greater. With SIGNED=1 and WIDTH=2, A=2'b11 (-1) vs B=0 gives less.
- Combinational compare: MSB-first cascade or a direct relational operator. Either is acceptable provided timing closes at WIDTH=32.

Decomposition:
- Shared package comparator_pkg:
  - cmp_result_e enum (CMP_LT, CMP_EQ, CMP_GT).
  - Helper function to_flags() mapping the enum to the three one-hot flags.
  - Constant CMP_MAX_WIDTH = 32.
- One natural sub-module: comparator_slice.
  - 1-bit cascade cell.
  - Takes the lt/eq/gt results from the more significant bits plus a_bit/b_bit, and produces the updated lt/eq/gt.
  - The top level instantiates WIDTH slices MSB-first, with an inverted-sense MSB slice when SIGNED=1, then registers the result.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=1, B=2 -> out_valid=0 and all flags 0 throughout. Release rst: flags stay 0 until the first valid sample.
- Less sweep (WIDTH=2, unsigned): (A,B)=(0,1),(1,2),(2,3),(3,0) with in_valid=1 every cycle:
  - First three -> A_less_B=1 one cycle later.
  - (3,0), where B wrapped to 0 from an upstream 4 -> A_greater_B=1.
  - out_valid stays high continuously.
- Equal sweep: (0,0),(1,1),(2,2),(3,3) -> A_equal_B=1 on each result cycle, other flags 0.
- Greater sweep: (1,0),(2,1),(3,2),(0,3), where A wrapped from 4 -> first three A_greater_B=1, last A_less_B=1.
- Hold/idle: valid (2,1), then in_valid=0 for 3 cycles while A/B toggle randomly -> out_valid drops to 0, A_greater_B stays 1, other flags stay 0.
- Signed plus reset mid-stream:
  - SIGNED=1, WIDTH=2: (3,0) -> A_less_B=1; (1,2) -> A_greater_B=1.
  - Assert rst alongside a valid pair -> next cycle out_valid=0 and all flags 0.

Source files
------------

// File: rtl/comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comparator_pkg
// Description : Shared result encoding and flag mapping for the comparator.
// Revision    : 1.0
// ============================================================================
package comparator_pkg;

    localparam int CMP_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_flags_t;

    function automatic cmp_flags_t to_flags(input cmp_result_e res);
        cmp_flags_t f;
        f = '0;
        case (res)
            CMP_LT:  f.lt = 1'b1;
            CMP_EQ:  f.eq = 1'b1;
            CMP_GT:  f.gt = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comparator_slice.sv
`default_nettype none
// ============================================================================
// Module      : comparator_slice
// Description : One-bit cell of an MSB-first magnitude compare cascade.
// Revision    : 1.0
// ============================================================================
module comparator_slice
    import comparator_pkg::*;
#(
    parameter bit INVERT = 1'b0
) (
    input  logic lt_in,
    input  logic eq_in,
    input  logic gt_in,
    input  logic a_bit,
    input  logic b_bit,
    output logic lt_out,
    output logic eq_out,
    output logic gt_out
);

    logic w_a_wins;
    logic w_b_wins;

    // A set sign bit means a smaller two's-complement value, so the
    // signed MSB cell swaps which operand wins.
    assign w_a_wins = INVERT ? (~a_bit & b_bit) : (a_bit & ~b_bit);
    assign w_b_wins = INVERT ? (a_bit & ~b_bit) : (~a_bit & b_bit);

    // Once a more significant bit has decided the order, it is passed through.
    assign gt_out = gt_in | (eq_in & w_a_wins);
    assign lt_out = lt_in | (eq_in & w_b_wins);
    assign eq_out = eq_in & ~(a_bit ^ b_bit);

endmodule
`default_nettype wire

// File: rtl/comparator.sv
`default_nettype none
// ============================================================================
// Module      : comparator
// Description : Registered unsigned/signed magnitude comparator, 1-cycle latency.
// Revision    : 1.0
// ============================================================================
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_less_B,
    output logic             A_equal_B,
    output logic             A_greater_B
);

    // Index WIDTH is the cascade seed ("equal so far"); index 0 is the result.
    logic [WIDTH:0] w_lt;
    logic [WIDTH:0] w_eq;
    logic [WIDTH:0] w_gt;

    cmp_result_e w_result;
    cmp_flags_t  w_flags;

    logic       r_out_valid;
    cmp_flags_t r_flags;

    assign w_lt[WIDTH] = 1'b0;
    assign w_eq[WIDTH] = 1'b1;
    assign w_gt[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        comparator_slice #(
            .INVERT ((SIGNED != 0) && (i == WIDTH - 1))
        ) u_slice (
            .lt_in  (w_lt[i+1]),
            .eq_in  (w_eq[i+1]),
            .gt_in  (w_gt[i+1]),
            .a_bit  (A[i]),
            .b_bit  (B[i]),
            .lt_out (w_lt[i]),
            .eq_out (w_eq[i]),
            .gt_out (w_gt[i])
        );
    end

    always_comb begin
        w_result = CMP_EQ;
        if (w_lt[0]) begin
            w_result = CMP_LT;
        end else if (w_gt[0]) begin
            w_result = CMP_GT;
        end
        w_flags = to_flags(w_result);
    end

    // Flags only update on a valid sample so they hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_flags     <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign A_less_B    = r_flags.lt;
    assign A_equal_B   = r_flags.eq;
    assign A_greater_B = r_flags.gt;

endmodule
`default_nettype wire

// File: tb/tb_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator
// Description : Directed self-checking bench for unsigned and signed 2-bit comparators.
// Revision    : 1.0
// ============================================================================
module tb_comparator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] A;
    logic [1:0] B;

    logic u_valid, u_lt, u_eq, u_gt;
    logic s_valid, s_lt, s_eq, s_gt;

    int total = 0;
    int bad   = 0;

    comparator #(.WIDTH(2), .SIGNED(0)) dut_u (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .A           (A),
        .B           (B),
        .out_valid   (u_valid),
        .A_less_B    (u_lt),
        .A_equal_B   (u_eq),
        .A_greater_B (u_gt)
    );

    comparator #(.WIDTH(2), .SIGNED(1)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .A           (A),
        .B           (B),
        .out_valid   (s_valid),
        .A_less_B    (s_lt),
        .A_equal_B   (s_eq),
        .A_greater_B (s_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vectors are {out_valid, lt, eq, gt}.
    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] uvec();
        return {u_valid, u_lt, u_eq, u_gt};
    endfunction

    function automatic logic [3:0] svec();
        return {s_valid, s_lt, s_eq, s_gt};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;

        // Reset overrides a valid pair
        step(1'b1, 1'b1, 2'd1, 2'd2); check("rst0_u", uvec(), 4'b0000); check("rst0_s", svec(), 4'b0000);
        step(1'b1, 1'b1, 2'd1, 2'd2); check("rst1_u", uvec(), 4'b0000); check("rst1_s", svec(), 4'b0000);
        step(1'b0, 1'b0, 2'd1, 2'd2); check("idle0_u", uvec(), 4'b0000);
        step(1'b0, 1'b0, 2'd3, 2'd0); check("idle1_u", uvec(), 4'b0000);

        // Less sweep, back-to-back
        step(1'b0, 1'b1, 2'd0, 2'd1); check("lt_0_1", uvec(), 4'b1100);
        step(1'b0, 1'b1, 2'd1, 2'd2); check("lt_1_2", uvec(), 4'b1100);
        step(1'b0, 1'b1, 2'd2, 2'd3); check("lt_2_3", uvec(), 4'b1100);
        step(1'b0, 1'b1, 2'd3, 2'd0); check("lt_3_0", uvec(), 4'b1001);

        // Equal sweep, including 0 and max
        step(1'b0, 1'b1, 2'd0, 2'd0); check("eq_0", uvec(), 4'b1010);
        step(1'b0, 1'b1, 2'd1, 2'd1); check("eq_1", uvec(), 4'b1010);
        step(1'b0, 1'b1, 2'd2, 2'd2); check("eq_2", uvec(), 4'b1010);
        step(1'b0, 1'b1, 2'd3, 2'd3); check("eq_3", uvec(), 4'b1010);

        // Greater sweep
        step(1'b0, 1'b1, 2'd1, 2'd0); check("gt_1_0", uvec(), 4'b1001);
        step(1'b0, 1'b1, 2'd2, 2'd1); check("gt_2_1", uvec(), 4'b1001);
        step(1'b0, 1'b1, 2'd3, 2'd2); check("gt_3_2", uvec(), 4'b1001);
        step(1'b0, 1'b1, 2'd0, 2'd3); check("gt_0_3", uvec(), 4'b1100);

        // Hold while idle with toggling operands
        step(1'b0, 1'b1, 2'd2, 2'd1); check("hold_src", uvec(), 4'b1001);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            check($sformatf("hold_%0d", k), uvec(), 4'b0001);
        end

        // Signed compares; unsigned instance sees the same bits
        step(1'b0, 1'b1, 2'd3, 2'd0); check("s_m1_0", svec(), 4'b1100); check("u_3_0", uvec(), 4'b1001);
        step(1'b0, 1'b1, 2'd1, 2'd2); check("s_1_m2", svec(), 4'b1001); check("u_1_2", uvec(), 4'b1100);
        step(1'b0, 1'b1, 2'd2, 2'd1); check("s_m2_1", svec(), 4'b1100);
        step(1'b0, 1'b1, 2'd2, 2'd2); check("s_m2_m2", svec(), 4'b1010);
        step(1'b0, 1'b1, 2'd1, 2'd3); check("s_1_m1", svec(), 4'b1001);
        step(1'b0, 1'b1, 2'd2, 2'd3); check("s_m2_m1", svec(), 4'b1100);

        // Reset mid-stream alongside a valid pair
        step(1'b1, 1'b1, 2'd3, 2'd0); check("mrst_u", uvec(), 4'b0000); check("mrst_s", svec(), 4'b0000);
        step(1'b0, 1'b0, 2'd1, 2'd0); check("post_u", uvec(), 4'b0000); check("post_s", svec(), 4'b0000);
        step(1'b0, 1'b1, 2'd1, 2'd0); check("resume_u", uvec(), 4'b1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
